// File: rtl/mips_trace_pkg.sv
// rtl/mips_trace_pkg.sv - shared types and constants for the MIPS trace transmitter
//
// Purpose: record layout, serializer state encoding and byte-select helper
// used by mips_trace_tx and its FIFO.
// Build option: TRACE_SYNC_EN prefixes every record with SYNC_BYTE.

package mips_trace_pkg;

  localparam int         REC_BYTES = 12;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef TRACE_SYNC_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  // Bytes on the wire per record, including the optional sync prefix.
  localparam int TX_BYTES = REC_BYTES + HDR_BYTES;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  // Field order matches transmit order: pc is sent first, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
  } trace_rec_t;

  // Byte k (0 = first on the wire) of a record, big-endian.
  function automatic logic [7:0] rec_byte(input trace_rec_t rec, input logic [3:0] k);
    logic [95:0] v;
    v = rec;
    v = v << {k, 3'b000};
    return v[95:88];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - parameterised synchronous FIFO for trace records
//
// Purpose: plain push/pop FIFO; the caller decides whether a push is allowed.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push, wdata     write wdata at the write pointer
//   pop, rdata      rdata is the current head (combinational); pop advances it
//   full, empty     occupancy flags
//   level           number of entries held

module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/mips_trace_tx.sv
// rtl/mips_trace_tx.sv - byte-serial execution-trace transmitter for the MIPS core
//
// Purpose: queues one record (PC, instruction, ALU result) per retired
// instruction and streams it out big-endian over a valid/ready byte interface.
// Records arriving with no FIFO space are dropped and counted.
// Build option: TRACE_SYNC_EN adds a 0xA5 prefix byte to every record.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   retire_valid/pc/instr/alu   retired-instruction capture from the core
//   tx_valid, tx_data, tx_last  output byte stream
//   tx_ready                    sink accepts the byte on this edge
//   fifo_level                  records queued, not counting the one being sent
//   overflow_cnt                dropped records, saturating at 0xFFFF

module mips_trace_tx
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     retire_valid,
  input  logic [31:0]              retire_pc,
  input  logic [31:0]              retire_instr,
  input  logic [31:0]              retire_alu,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_last,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              overflow_cnt
);

  tx_state_t  state;
  tx_state_t  state_nx;
  logic [3:0] byte_idx;
  logic [3:0] idx_nx;
  trace_rec_t cur_rec;
  trace_rec_t head;
  logic       push;
  logic       pop;
  logic       drop;
  logic       full;
  logic       empty;
  logic       at_last;
  logic [7:0] sel_byte;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_rec_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({retire_pc, retire_instr, retire_alu}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign at_last = (byte_idx == 4'(TX_BYTES - 1));

  always_comb begin
    state_nx = state;
    idx_nx   = byte_idx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = SEND;
          idx_nx   = '0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (at_last) begin
            idx_nx = '0;
            // Chain straight into the next record so there is no bubble.
            if (!empty) pop = 1'b1;
            else        state_nx = IDLE;
          end else begin
            idx_nx = byte_idx + 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A full FIFO still has room when the head leaves on the same edge.
  assign push = retire_valid && (!full || pop);
  assign drop = retire_valid && !push;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      byte_idx     <= '0;
      cur_rec      <= '0;
      overflow_cnt <= '0;
    end else begin
      state    <= state_nx;
      byte_idx <= idx_nx;
      if (pop) cur_rec <= head;
      if (drop && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  always_comb begin
`ifdef TRACE_SYNC_EN
    if (byte_idx == 4'd0) sel_byte = SYNC_BYTE;
    else                  sel_byte = rec_byte(cur_rec, byte_idx - 4'd1);
`else
    sel_byte = rec_byte(cur_rec, byte_idx);
`endif
  end

  // Outputs are forced to zero outside SEND so the idle bus is quiet.
  assign tx_valid = (state == SEND);
  assign tx_last  = (state == SEND) && at_last;
  assign tx_data  = (state == SEND) ? sel_byte : 8'h00;

endmodule

// File: tb/tb_mips_trace_tx.sv
// tb/tb_mips_trace_tx.sv - scoreboard testbench for mips_trace_tx

module tb_mips_trace_tx;

  localparam int DEPTH = 8;
`ifdef TRACE_SYNC_EN
  localparam int LEN = 13;
`else
  localparam int LEN = 12;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_instr = '0;
  logic [31:0] retire_alu = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] overflow_cnt;

  mips_trace_tx #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_instr (retire_instr),
    .retire_alu   (retire_alu),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   rx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_sync();
`ifdef TRACE_SYNC_EN
    exp_q.push_back('{8'hA5, 1'b0});
`endif
  endtask

  task automatic expect_rec(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu);
    logic [95:0] r;
    r = {pc, instr, alu};
    push_sync();
    for (int i = 0; i < 12; i++) exp_q.push_back('{r[95-8*i -: 8], (i == 11)});
  endtask

  // Hand-listed bytes of PC=4, instr=0x20080005, alu=5.
  task automatic expect_first_rec();
    logic [7:0] b [12];
    b = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h05};
    push_sync();
    for (int i = 0; i < 12; i++) exp_q.push_back('{b[i], (i == 11)});
  endtask

  task automatic set_retire(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_instr = instr;
    retire_alu   = alu;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_rx(input string name, input int target, input int budget);
    for (int i = 0; i < budget && rx_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    check(name, 32'(rx_cnt >= target), 32'd1);
  endtask

  // Monitor: every presented byte is compared with the scoreboard head; the
  // head is retired only on a handshake, so held bytes are rechecked each cycle.
  always @(negedge clk) begin
    if (reset && tx_valid) begin
      if (exp_q.size() == 0) begin
        if (tx_ready) begin
          chk_cnt++;
          $display("FAIL unexpected_byte: got 0x%0h, required no byte", tx_data);
        end
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_q[0].data));
        check("tx_last", 32'(tx_last), 32'(exp_q[0].last));
        if (tx_ready) begin
          void'(exp_q.pop_front());
          rx_cnt++;
        end
      end
    end
  end

  int base;
  logic found;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single record, latency and idle-after.
    base = rx_cnt;
    tx_ready = 1'b1;
    expect_first_rec();
    set_retire(32'h0000_0004, 32'h2008_0005, 32'h0000_0005);
    @(posedge clk); #1;
    retire_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_e0", 32'(tx_valid), 32'd0);
    check("lat_level_e0", 32'(fifo_level), 32'd1);
    @(negedge clk);
    check("lat_valid_e1", 32'(tx_valid), 32'd1);
    check("lat_level_e1", 32'(fifo_level), 32'd0);
    @(posedge clk); #1;
    wait_drain("single_drain", 40);
    check("single_count", 32'(rx_cnt - base), 32'(LEN));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("single_idle", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure mid-record.
    base = rx_cnt;
    expect_first_rec();
    set_retire(32'h0000_0004, 32'h2008_0005, 32'h0000_0005);
    @(posedge clk); #1;
    retire_valid = 1'b0;
    wait_rx("bp_start", base + 4, 40);
    tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_drain("bp_drain", 40);
    check("bp_count", 32'(rx_cnt - base), 32'(LEN));

    // Overflow: 20 retires with the sink stalled.
    base = rx_cnt;
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_retire(32'h0000_1000 + 32'(4 * i), 32'h2008_0000 + 32'(i), 32'hAB00_0000 + 32'(3 * i));
      if (i < 9) expect_rec(32'h0000_1000 + 32'(4 * i), 32'h2008_0000 + 32'(i), 32'hAB00_0000 + 32'(3 * i));
      @(posedge clk); #1;
    end
    retire_valid = 1'b0;
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_count", 32'(overflow_cnt), 32'd11);
    tx_ready = 1'b1;
    wait_drain("ovf_drain", 9 * LEN + 40);
    check("ovf_rx", 32'(rx_cnt - base), 32'(9 * LEN));

    // Full FIFO with a push on the last-byte handshake edge.
    base = rx_cnt;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_retire(32'h0040_0000 + 32'(4 * i), 32'h8C09_0000 + 32'(i), 32'h1234_5600 + 32'(i));
      expect_rec(32'h0040_0000 + 32'(4 * i), 32'h8C09_0000 + 32'(i), 32'h1234_5600 + 32'(i));
      @(posedge clk); #1;
    end
    retire_valid = 1'b0;
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_ovf_before", 32'(overflow_cnt), 32'd11);
    tx_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tx_valid && tx_last) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("full_last_seen", 32'(found), 32'd1);
    set_retire(32'hDEAD_BEE0, 32'h0123_4567, 32'h89AB_CDEF);
    expect_rec(32'hDEAD_BEE0, 32'h0123_4567, 32'h89AB_CDEF);
    @(posedge clk); #1;
    retire_valid = 1'b0;
    check("full_pop_level", 32'(fifo_level), 32'd8);
    check("full_pop_ovf", 32'(overflow_cnt), 32'd11);
    wait_drain("full_drain", 10 * LEN + 40);
    check("full_rx", 32'(rx_cnt - base), 32'(10 * LEN));

    // Reset after byte 5 of a record.
    base = rx_cnt;
    expect_rec(32'h0000_0100, 32'h0000_0020, 32'h0000_0000);
    set_retire(32'h0000_0100, 32'h0000_0020, 32'h0000_0000);
    @(posedge clk); #1;
    retire_valid = 1'b0;
    wait_rx("rst_mid_start", base + 5, 40);
    tx_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    check("rst_mid_ovf", 32'(overflow_cnt), 32'd0);
    @(posedge clk); #1;
    base = rx_cnt;
    tx_ready = 1'b1;
    expect_rec(32'h0000_0200, 32'h3C01_1001, 32'h1001_0000);
    set_retire(32'h0000_0200, 32'h3C01_1001, 32'h1001_0000);
    @(posedge clk); #1;
    retire_valid = 1'b0;
    wait_drain("post_rst_drain", 40);
    check("post_rst_count", 32'(rx_cnt - base), 32'(LEN));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
